// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizer plus four-state qualifier turning a bouncing input
// into a clean registered level with one-cycle rise/fall strobes.
module input_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic q_bar,
   output logic rise,
   output logic fall,
   output logic busy
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("input_debouncer: SYNC_STAGES must be in 2..4");
   end
   if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("input_debouncer: STABLE_CYCLES must be in 2..65535");
   end

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   d_sync;
   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   q_nxt, rise_nxt, fall_nxt, busy_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], d};
   end

   assign d_sync = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STABLE_LO;
         cnt   <= '0;
         q     <= 1'b0;
         q_bar <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         q_bar <= ~q_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
         busy  <= busy_nxt;
      end
   end

   // The count only advances inside a CHK state and is cleared on every exit, so it never wraps.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      unique case (state)
         STABLE_LO: if (d_sync) begin
            state_nxt = CHK_HI;
            cnt_nxt   = CW'(1);
         end
         CHK_HI: if (!d_sync) begin
            state_nxt = STABLE_LO;
         end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HI;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
         STABLE_HI: if (!d_sync) begin
            state_nxt = CHK_LO;
            cnt_nxt   = CW'(1);
         end
         CHK_LO: if (d_sync) begin
            state_nxt = STABLE_HI;
         end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE_LO;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
         default: state_nxt = STABLE_LO;
      endcase
   end

   always_comb begin
      rise_nxt = (state == CHK_HI) && d_sync && (cnt == CNT_LAST);
      fall_nxt = (state == CHK_LO) && !d_sync && (cnt == CNT_LAST);
      q_nxt    = q;
      if (rise_nxt)      q_nxt = 1'b1;
      else if (fall_nxt) q_nxt = 1'b0;
      busy_nxt = (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
   end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench: stimulus queues expected rise/fall pulses
// with their cycle, a negedge monitor pops and compares each pulse the DUT produces.
module tb_input_debouncer;

   logic clk = 1'b0;
   logic rst_n, d;
   logic q, q_bar, rise, fall, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit is_rise;
      int cyc;
   } exp_t;
   exp_t sb[$];

   input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .d(d),
      .q(q), .q_bar(q_bar), .rise(rise), .fall(fall), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_pulse(input bit is_rise, input int at);
      exp_t e;
      e.is_rise = is_rise;
      e.cyc     = at;
      sb.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse must match the head of the scoreboard in kind and cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) check("q_bar_compl", q_bar, ~q);
      if (rise && fall) begin
         checks++; errors++;
         $display("FAIL rise_fall_overlap: both high at cycle %0d", cyc);
      end else if (rise || fall) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, none expected", rise, fall, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.is_rise != rise || e.cyc != cyc) begin
               errors++;
               $display("FAIL pulse: got rise=%b at cycle %0d expected rise=%b at cycle %0d",
                        rise, cyc, e.is_rise, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      bit q_moved, busy_seen;

      // Reset state
      rst_n = 1'b0; d = 1'b0;
      wait_cycles(3);
      check("rst_q", q, 1'b0);
      check("rst_q_bar", q_bar, 1'b1);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      wait_cycles(3);

      // Clean rise
      d = 1'b1; base = cyc;
      expect_pulse(1'b1, base + 6);
      wait_cycles(2); check("rise_busy_e2", busy, 1'b0);
      wait_cycles(1); check("rise_busy_e3", busy, 1'b1);
      wait_cycles(2); check("rise_q_e5", q, 1'b0);
      wait_cycles(1); check("rise_q_e6", q, 1'b1);
      check("rise_qbar_e6", q_bar, 1'b0);
      check("rise_pulse_e6", rise, 1'b1);
      wait_cycles(1); check("rise_pulse_e7", rise, 1'b0);
      check("rise_busy_e7", busy, 1'b0);
      wait_cycles(3);

      // Clean fall
      d = 1'b0; base = cyc;
      expect_pulse(1'b0, base + 6);
      wait_cycles(5); check("fall_q_e5", q, 1'b1);
      wait_cycles(1); check("fall_q_e6", q, 1'b0);
      check("fall_qbar_e6", q_bar, 1'b1);
      check("fall_pulse_e6", fall, 1'b1);
      wait_cycles(4);

      // Glitch reject: two-cycle high excursion
      d = 1'b1;
      wait_cycles(2);
      d = 1'b0;
      q_moved = 0; busy_seen = 0;
      for (int i = 0; i < 12; i++) begin
         wait_cycles(1);
         if (q !== 1'b0) q_moved = 1;
         if (busy === 1'b1) busy_seen = 1;
      end
      check("glitch_q_held", q_moved, 1'b0);
      check("glitch_busy_seen", busy_seen, 1'b1);

      // Bounce then hold high
      for (int i = 0; i < 10; i++) begin
         d = (i % 2 == 0);
         wait_cycles(1);
      end
      d = 1'b1; base = cyc;
      expect_pulse(1'b1, base + 6);
      wait_cycles(5); check("bounce_q_e5", q, 1'b0);
      wait_cycles(1); check("bounce_q_e6", q, 1'b1);
      wait_cycles(4);

      // Second clean fall
      d = 1'b0; base = cyc;
      expect_pulse(1'b0, base + 6);
      wait_cycles(8);
      check("fall2_q", q, 1'b0);

      // Reset mid-count in CHK_HI
      d = 1'b1;
      wait_cycles(4);
      check("midrst_busy", busy, 1'b1);
      #2 rst_n = 1'b0; d = 1'b0;
      #1;
      check("midrst_busy0", busy, 1'b0);
      check("midrst_q", q, 1'b0);
      check("midrst_qbar", q_bar, 1'b1);
      wait_cycles(2);
      rst_n = 1'b1;
      q_moved = 0; busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         wait_cycles(1);
         if (q !== 1'b0) q_moved = 1;
         if (busy !== 1'b0) busy_seen = 1;
      end
      check("midrst_q_quiet", q_moved, 1'b0);
      check("midrst_busy_quiet", busy_seen, 1'b0);

      // Release reset with d already high
      rst_n = 1'b0; d = 1'b1;
      wait_cycles(2);
      rst_n = 1'b1; base = cyc;
      expect_pulse(1'b1, base + 6);
      wait_cycles(5); check("relhi_q_e5", q, 1'b0);
      wait_cycles(1); check("relhi_q_e6", q, 1'b1);
      wait_cycles(3);

      // Asynchronous reset mid-cycle with q=1, d=1
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("async_q", q, 1'b0);
      check("async_qbar", q_bar, 1'b1);
      check("async_rise", rise, 1'b0);
      check("async_fall", fall, 1'b0);
      check("async_busy", busy, 1'b0);
      wait_cycles(3);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_pulse: %0d expected pulses never seen, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
